// File: rtl/tcp_state_rd_arb_if.sv
// tcp_state_rd_arb_if: one valid/ready read channel into a per-flow state
// memory, i.e. a request (val/addr/rdy) plus an in-order response
// (val/data/rdy). The master issues reads and the slave serves them.
interface tcp_state_rd_arb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  logic              rd_req_val;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_req_rdy;
  logic              rd_resp_val;
  logic [DATA_W-1:0] rd_resp_data;
  logic              rd_resp_rdy;

  modport master (
    output rd_req_val, rd_req_addr, rd_resp_rdy,
    input  rd_req_rdy, rd_resp_val, rd_resp_data
  );

  modport slave (
    input  rd_req_val, rd_req_addr, rd_resp_rdy,
    output rd_req_rdy, rd_resp_val, rd_resp_data
  );
endinterface

// File: rtl/tcp_state_rd_arb.sv
// tcp_state_rd_arb: two-requester read arbiter for a single-read-port
// per-flow state RAM. Requester 0 is the RX pipeline and requester 1 is the
// TX/send pipeline. Each accepted request pushes its requester ID into a tag
// FIFO. Because the memory answers in order, the FIFO head tells us which
// requester owns the current response.
// Build option: TCP_STATE_RD_ARB_RR_EN selects round-robin tie breaking.
// Without it, requester 0 always wins a tie and no last-grant flop exists.
module tcp_state_rd_arb #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 64,
  parameter int TAG_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  tcp_state_rd_arb_if.slave        req0,
  tcp_state_rd_arb_if.slave        req1,
  tcp_state_rd_arb_if.master       mem,
  output logic                     arb_busy
);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic              full;
  logic              empty;
  logic              any_val;
  logic              gnt0;
  logic              gnt1;
  logic              push;
  logic              pop;
  logic              head;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] resp_data;

  // Full and empty come only from the count register, so the memory's
  // request-ready can never loop back into the request valid.
  assign full  = (count == CNT_W'(TAG_DEPTH));
  assign empty = (count == '0);

`ifdef TCP_STATE_RD_ARB_RR_EN
  logic last_grant;

  // On a tie, the requester that did not win the last accepted request
  // goes first.
  assign gnt0 = req0.rd_req_val & (~req1.rd_req_val | last_grant);

  // Remember who won the most recent accepted request. The reset value of 1
  // lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (push) begin
      last_grant <= gnt1;
    end
  end
`else
  // Fixed priority: RX always wins, so TX can be starved.
  assign gnt0 = req0.rd_req_val;
`endif

  assign gnt1    = req1.rd_req_val & ~gnt0;
  assign any_val = req0.rd_req_val | req1.rd_req_val;

  // Request path. The grant is re-evaluated every cycle, so a requester may
  // drop valid before it sees ready.
  assign gnt_addr         = gnt1 ? req1.rd_req_addr : req0.rd_req_addr;
  assign mem.rd_req_val   = any_val & ~full;
  assign mem.rd_req_addr  = gnt_addr;
  assign req0.rd_req_rdy  = gnt0 & ~full & mem.rd_req_rdy;
  assign req1.rd_req_rdy  = gnt1 & ~full & mem.rd_req_rdy;
  assign push             = mem.rd_req_val & mem.rd_req_rdy;

  // Response path. It is steered by the oldest outstanding tag, and only
  // the owning requester's ready can consume the response.
  assign head              = tag_mem[rd_ptr];
  assign resp_data         = mem.rd_resp_data;
  assign req0.rd_resp_data = resp_data;
  assign req1.rd_resp_data = resp_data;
  assign req0.rd_resp_val  = mem.rd_resp_val & ~empty & ~head;
  assign req1.rd_resp_val  = mem.rd_resp_val & ~empty &  head;
  assign mem.rd_resp_rdy   = ~empty & (head ? req1.rd_resp_rdy : req0.rd_resp_rdy);
  assign pop               = mem.rd_resp_val & mem.rd_resp_rdy;

  assign arb_busy = ~empty;

  // Tag FIFO: push the winner's ID on a request handshake and pop on a
  // response handshake. TAG_DEPTH is a power of two, so the pointers wrap
  // naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= gnt1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // The memory must never answer while no read is outstanding.
  a_resp_needs_tag: assert property (
    @(posedge clk) disable iff (!rst) !(mem.rd_resp_val && empty)
  );
endmodule

// File: doc/tcp_state_rd_arb.md
# tcp_state_rd_arb

Two-requester read arbiter for a single-read-port per-flow state memory (TX or RX state RAM). Sits between the RX pipeline (requester 0) and the TX/send pipeline (requester 1) and the memory's valid/ready read request and response channels. Grants one request per cycle, records the grant order in a tag FIFO, and steers each in-order memory response back to the requester that issued it.

## Interface
Parameters:
- ADDR_W, FLOWID_W: read address width (flow ID).
- DATA_W, 64: state word width (e.g. smol_tx_state_struct width).
- TAG_DEPTH, 4: maximum outstanding reads; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req0_rd_req_val / req1_rd_req_val  in  1  requester read request valid.
- req0_rd_req_addr / req1_rd_req_addr  in  ADDR_W  flow ID to read.
- req0_rd_req_rdy / req1_rd_req_rdy  out  1  request accepted.
- req0_rd_resp_val / req1_rd_resp_val  out  1  response valid to requester.
- req0_rd_resp_data / req1_rd_resp_data  out  DATA_W  response data (shared mem_rd_resp_data).
- req0_rd_resp_rdy / req1_rd_resp_rdy  in  1  requester can take response.
- mem_rd_req_val  out  1  request to memory.
- mem_rd_req_addr  out  ADDR_W  granted address.
- mem_rd_req_rdy  in  1  memory accepts request.
- mem_rd_resp_val  in  1  memory response valid; responses return in request order.
- mem_rd_resp_data  in  DATA_W  memory response data.
- mem_rd_resp_rdy  out  1  response consumed.
- arb_busy  out  1  at least one read outstanding.

## Operation
- Tag FIFO: TAG_DEPTH entries × 1 bit (requester ID), with a count register of width log2(TAG_DEPTH)+1. Push on mem request handshake, pop on mem response handshake.
- Request path is combinational:
  - full = (count == TAG_DEPTH).
  - grant = arbitration among valid requesters when !full; mem_rd_req_val = (req0 | req1 valid) & !full.
  - mem_rd_req_addr = granted requester's address.
  - reqN_rd_req_rdy = grant==N & mem_rd_req_rdy & !full.
- Arbitration (round-robin, see Configuration): a last-grant register selects the priority. If only one requester is valid, it wins. If both are valid, the requester that was not last granted wins. The last-grant register updates only on a request handshake.
- Response path is combinational:
  - head = tag FIFO head entry.
  - reqN_rd_resp_val = mem_rd_resp_val & !empty & head==N.
  - mem_rd_resp_rdy = !empty & reqN_rd_resp_rdy for N = head.
  - The other requester's resp_val stays 0.
- No state machine beyond FIFO pointers, count and last-grant register.
- Boundaries:
  - Full: no grant, even if a pop occurs in the same cycle. Re-grant happens the following cycle.
  - Push and pop in the same cycle (not full): count unchanged, both pointers advance.
  - Pointers wrap modulo TAG_DEPTH.
  - mem_rd_resp_val while empty is illegal: mem_rd_resp_rdy=0 and a simulation assertion fires.
  - A requester dropping val before rdy is legal. The request is not latched and arbitration re-evaluates each cycle.
  - Reset mid-operation: all outstanding tags are discarded. Memory responses arriving after reset see empty and are not consumed. The memory side is reset in the same domain.

## Timing
- Reset values:
  - count=0, rd/wr pointers=0, last-grant=1 (requester 0 wins first tie).
  - All *_val and *_rdy outputs=0 while inputs are idle; arb_busy=0.
- Request latency: 0 cycles, requester to memory, combinational.
- Response latency: 0 cycles, memory to requester, combinational.
- Throughput: 1 request and 1 response per cycle.
- arb_busy = (count != 0), registered-state derived.
- No combinational path from mem_rd_req_rdy to mem_rd_req_val. The FIFO outputs used for the request path come from registers.

## Configuration
- TCP_STATE_RD_ARB_RR_EN defined: round-robin arbitration as described.
- TCP_STATE_RD_ARB_RR_EN not defined:
  - Fixed priority: requester 0 (RX) always wins a tie.
  - The last-grant register is not instantiated.
  - Requester 1 can be starved by continuous requester-0 traffic.
- All other behaviour is identical in both builds.

## Test plan
- Single read: req0 addr=5 with mem_rd_req_rdy=1, memory returns 0xABCD one cycle later → req0_rd_resp_val=1 with data 0xABCD; req1_rd_resp_val stays 0; arb_busy 1 for exactly one cycle.
- Tie, RR build: both requesters valid for 4 cycles, memory always ready → grants 0,1,0,1. Responses delivered in order 0,1,0,1 to the matching requester.
- Tie, fixed-priority build: same stimulus → four grants to requester 0 and req1_rd_req_rdy=0 throughout.
- Full: TAG_DEPTH=4, memory withholds responses, 6 requests offered → exactly 4 accepted and count=4. After one response handshake, the next grant occurs the cycle after the pop.
- Response backpressure: head tag=1 and req1_rd_resp_rdy=0 for 3 cycles → mem_rd_resp_rdy=0 for those cycles and the FIFO is not popped. Data is delivered once rdy rises.
- Reset: rst asserted low with 3 reads outstanding → count=0 and arb_busy=0 immediately. A stale mem_rd_resp_val afterwards sees mem_rd_resp_rdy=0 and no requester resp_val.
